vk_reset_seq: RTL and testbench

Parametrised reset synchroniser and sequencer. Takes the board-level asynchronous active-low reset and runs it through a configurable-depth synchroniser. It then holds all domains in reset for a minimum stretch and releases `NUM_OUT` active-low synchronous resets one at a time, a fixed number of cycles apart. It sits at the top of each clock domain, in front of the search RAM pipeline, the controllers and the interface logic that must come out of reset in a defined order.

---
 rtl/vk_reset_seq.sv | 82 ++++++++
 tb/tb_vk_reset_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/vk_reset_seq.sv
// vk_reset_seq: reset synchroniser plus sequencer releasing NUM_OUT active-low resets in order.
// Optional software reset input enabled by defining VK_RESET_SEQ_SWRST_EN.
module vk_reset_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_OUT     = 4,
  parameter int STRETCH     = 16,
  parameter int STEP        = 8
) (
  input  logic               clk_i,
  input  logic               areset_i,
`ifdef VK_RESET_SEQ_SWRST_EN
  input  logic               swrst_i,
`endif
  output logic [NUM_OUT-1:0] sreset_o,
  output logic               done_o
);
  localparam int MAXC = (STRETCH > STEP) ? STRETCH : STEP;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {HOLD, RELEASE, DONE} state_t;

  (* shreg_extract = "no", ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_sync;
  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [NUM_OUT-1:0] r_sreset;
  logic               r_done;
  logic               w_sync_ok;
  logic               w_swrst;
  logic               w_due;
  logic [NUM_OUT-1:0] w_next;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("vk_reset_seq: SYNC_STAGES must be at least 2");
  end
  if (NUM_OUT < 1 || STRETCH < 1 || STEP < 1) begin : g_bad_cfg
    $error("vk_reset_seq: NUM_OUT, STRETCH and STEP must be at least 1");
  end

  assign w_sync_ok = r_sync[SYNC_STAGES-1];
`ifdef VK_RESET_SEQ_SWRST_EN
  assign w_swrst = swrst_i;
`else
  assign w_swrst = 1'b0;
`endif
  // Next release pattern: one more channel shifted in from bit 0; all-ones means last channel.
  assign w_next = (r_sreset << 1) | NUM_OUT'(1);
  assign w_due  = (r_state == HOLD && w_sync_ok && r_cnt == CW'(STRETCH - 1)) ||
                  (r_state == RELEASE && r_cnt == CW'(STEP - 1));

  // Synchroniser chain: async clear, shifts in ones once reset is removed.
  always_ff @(posedge clk_i or negedge areset_i) begin
    if (!areset_i) r_sync <= '0;
    else           r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
  end

  // Sequencer: hold for STRETCH synced cycles, then release one channel every STEP cycles.
  always_ff @(posedge clk_i or negedge areset_i) begin
    if (!areset_i) begin
      r_state  <= HOLD;
      r_cnt    <= '0;
      r_sreset <= '0;
      r_done   <= 1'b0;
    end else if (w_swrst) begin
      r_state  <= HOLD;
      r_cnt    <= '0;
      r_sreset <= '0;
      r_done   <= 1'b0;
    end else if (r_state != DONE) begin
      if (w_due) begin
        r_sreset <= w_next;
        r_cnt    <= '0;
        r_state  <= (&w_next) ? DONE : RELEASE;
        r_done   <= &w_next;
      end else if (r_state == RELEASE || w_sync_ok) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign sreset_o = r_sreset;
  assign done_o   = r_done;
endmodule

// File: tb/tb_vk_reset_seq.sv
// tb_vk_reset_seq: checks default and minimal-parameter sequencers against an edge-count model.
module tb_vk_reset_seq;
  logic       clk = 1'b0;
  logic       areset_n = 1'b0;
  logic       swrst = 1'b0;
  logic [3:0] sr;
  logic       done;
  logic [0:0] sr2;
  logic       done2;
  int checks = 0, failures = 0, k = 0, last_sw = 0, e = 0;

  always #5 clk = ~clk;

  vk_reset_seq dut (
    .clk_i(clk), .areset_i(areset_n),
`ifdef VK_RESET_SEQ_SWRST_EN
    .swrst_i(swrst),
`endif
    .sreset_o(sr), .done_o(done));

  vk_reset_seq #(.SYNC_STAGES(3), .NUM_OUT(1), .STRETCH(1), .STEP(1)) dut2 (
    .clk_i(clk), .areset_i(areset_n),
`ifdef VK_RESET_SEQ_SWRST_EN
    .swrst_i(swrst),
`endif
    .sreset_o(sr2), .done_o(done2));

  typedef struct {int edge_n; logic [3:0] sr; logic done; logic sr2;} vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d actual=%0h required=%0h", name, k, act, exp);
    end
  endtask

  // Channel i is up once k edges have passed the start point plus STRETCH + i*STEP.
  function automatic logic [3:0] model_sr(input int kk, input int ready);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (kk >= ready + 16 + i * 8);
    return r;
  endfunction

  task automatic check_model();
    int r1, r2;
    logic [3:0] m;
    r1 = (last_sw > 2) ? last_sw : 2;
    r2 = (last_sw > 3) ? last_sw : 3;
    m = model_sr(k, r1);
    chk("model_sr", sr, m);
    chk("model_done", done, &m);
    chk("model_sr2", sr2, k >= r2 + 1);
    chk("model_done2", done2, k >= r2 + 1);
  endtask

  task automatic tick();
    logic sw;
    sw = swrst;
    @(posedge clk);
    k++;
`ifdef VK_RESET_SEQ_SWRST_EN
    if (sw) last_sw = k;
`endif
    #1;
    check_model();
  endtask

  task automatic tick_to(input int target);
    while (k < target) tick();
  endtask

  task automatic do_areset();
    #2 areset_n = 1'b0;
    #1;
    chk("async_sr", sr, 4'h0);
    chk("async_done", done, 1'b0);
    chk("async_sr2", sr2, 1'b0);
    chk("async_done2", done2, 1'b0);
    #1 areset_n = 1'b1;
    k = 0;
    last_sw = 0;
  endtask

  initial begin
    tbl[0]  = '{3, 4'h0, 1'b0, 1'b0};
    tbl[1]  = '{4, 4'h0, 1'b0, 1'b1};
    tbl[2]  = '{17, 4'h0, 1'b0, 1'b1};
    tbl[3]  = '{18, 4'h1, 1'b0, 1'b1};
    tbl[4]  = '{25, 4'h1, 1'b0, 1'b1};
    tbl[5]  = '{26, 4'h3, 1'b0, 1'b1};
    tbl[6]  = '{33, 4'h3, 1'b0, 1'b1};
    tbl[7]  = '{34, 4'h7, 1'b0, 1'b1};
    tbl[8]  = '{41, 4'h7, 1'b0, 1'b1};
    tbl[9]  = '{42, 4'hf, 1'b1, 1'b1};
    tbl[10] = '{60, 4'hf, 1'b1, 1'b1};
    #23;
    chk("reset_sr", sr, 4'h0);
    chk("reset_done", done, 1'b0);
    chk("reset_sr2", sr2, 1'b0);
    chk("reset_done2", done2, 1'b0);
    areset_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick_to(tbl[i].edge_n);
      chk("tbl_sr", sr, tbl[i].sr);
      chk("tbl_done", done, tbl[i].done);
      chk("tbl_sr2", sr2, tbl[i].sr2);
    end
    do_areset();
    tick_to(30);
    chk("mid_sr", sr, 4'h3);
    do_areset();
    tick_to(18);
    chk("restart_sr", sr, 4'h1);
    tick_to(42);
    chk("restart_done", done, 1'b1);
`ifdef VK_RESET_SEQ_SWRST_EN
    swrst = 1'b1;
    tick();
    chk("sw_done_sr", sr, 4'h0);
    chk("sw_done_done", done, 1'b0);
    tick();
    tick();
    swrst = 1'b0;
    e = k;
    tick_to(e + 15);
    chk("sw_pre_bit0", sr, 4'h0);
    tick();
    chk("sw_bit0", sr, 4'h1);
    tick_to(e + 40);
    chk("sw_bit3", sr, 4'hf);
    chk("sw_done", done, 1'b1);
    do_areset();
    tick_to(25);
    swrst = 1'b1;
    tick();
    swrst = 1'b0;
    chk("collide_sr", sr, 4'h0);
    tick_to(41);
    chk("collide_pre", sr, 4'h0);
    tick();
    chk("collide_bit0", sr, 4'h1);
    do_areset();
    swrst = 1'b1;
    tick();
    swrst = 1'b0;
    tick_to(18);
    chk("fill_sw_bit0", sr, 4'h1);
`endif
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 3) do_areset();
`ifdef VK_RESET_SEQ_SWRST_EN
      swrst = (r >= 3 && r < 15);
`endif
      tick();
    end
    swrst = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
